// File: rtl/tap_pkg.sv
// Shared TAP controller encodings: state codes, instruction opcodes and IR capture pattern.
package tap_pkg;

  localparam int IR_WIDTH_DEF = 4;

  typedef enum logic [3:0] {
    EX2DR   = 4'h0,
    EX1DR   = 4'h1,
    SHDR    = 4'h2,
    PAUSEDR = 4'h3,
    SELIR   = 4'h4,
    UPDDR   = 4'h5,
    CAPDR   = 4'h6,
    SELDR   = 4'h7,
    EX2IR   = 4'h8,
    EX1IR   = 4'h9,
    SHIR    = 4'hA,
    PAUSEIR = 4'hB,
    RTI     = 4'hC,
    UPDIR   = 4'hD,
    CAPIR   = 4'hE,
    TLR     = 4'hF
  } tap_state_e;

  localparam logic [IR_WIDTH_DEF-1:0] OP_EXTEST  = 4'b0000;
  localparam logic [IR_WIDTH_DEF-1:0] OP_SAMPLE  = 4'b0001;
  localparam logic [IR_WIDTH_DEF-1:0] OP_IDCODE  = 4'b0010;
  localparam logic [IR_WIDTH_DEF-1:0] OP_BYPASS  = 4'b1111;
  localparam logic [IR_WIDTH_DEF-1:0] IR_CAPTURE = 4'b0001;

endpackage

// File: rtl/tap_fsm.sv
// 16-state TAP controller state machine, advanced by TMS on the rising edge of TCK.
module tap_fsm
  import tap_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  output tap_state_e state
);

  tap_state_e state_q;

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      state_q <= TLR;
    end else begin
      case (state_q)
        TLR:     state_q <= TMS ? TLR   : RTI;
        RTI:     state_q <= TMS ? SELDR : RTI;
        SELDR:   state_q <= TMS ? SELIR : CAPDR;
        CAPDR:   state_q <= TMS ? EX1DR : SHDR;
        SHDR:    state_q <= TMS ? EX1DR : SHDR;
        EX1DR:   state_q <= TMS ? UPDDR : PAUSEDR;
        PAUSEDR: state_q <= TMS ? EX2DR : PAUSEDR;
        EX2DR:   state_q <= TMS ? UPDDR : SHDR;
        UPDDR:   state_q <= TMS ? SELDR : RTI;
        SELIR:   state_q <= TMS ? TLR   : CAPIR;
        CAPIR:   state_q <= TMS ? EX1IR : SHIR;
        SHIR:    state_q <= TMS ? EX1IR : SHIR;
        EX1IR:   state_q <= TMS ? UPDIR : PAUSEIR;
        PAUSEIR: state_q <= TMS ? EX2IR : PAUSEIR;
        EX2IR:   state_q <= TMS ? UPDIR : SHIR;
        UPDIR:   state_q <= TMS ? SELDR : RTI;
        default: state_q <= TLR;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: rtl/tap_ctrl.sv
// TAP controller top: instruction/data registers, BSR strobe decode and TDO multiplexing.
module tap_ctrl
  import tap_pkg::*;
#(
  parameter int          IR_WIDTH   = IR_WIDTH_DEF,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  input  logic       TDI,
  input  logic       bsr_so,
  output logic       TDO,
  output logic       tdo_en,
  output logic       ShiftDR,
  output logic       CaptureDR,
  output logic       UpdateDR,
  output logic       mode,
  output logic [3:0] state
);

  tap_state_e          fsmState;
  logic [IR_WIDTH-1:0] irShift_q;
  logic [IR_WIDTH-1:0] irActive_q;
  logic                bypass_q;
  logic [31:0]         idcode_q;
  logic                tdo_q, tdoEn_q;
  logic                tdo_d, tdoEn_d;
  logic                bsrSel, idcodeSel, drBit;

  tap_fsm uFsm (
    .TCK   (TCK),
    .TRST  (TRST),
    .TMS   (TMS),
    .state (fsmState)
  );

  assign state = fsmState;

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      irShift_q <= IR_WIDTH'(IR_CAPTURE);
    end else if (fsmState == CAPIR) begin
      irShift_q <= IR_WIDTH'(IR_CAPTURE);
    end else if (fsmState == SHIR) begin
      irShift_q <= {TDI, irShift_q[IR_WIDTH-1:1]};
    end
  end

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      bypass_q <= 1'b0;
    end else if (fsmState == CAPDR) begin
      bypass_q <= 1'b0;
    end else if (fsmState == SHDR) begin
      bypass_q <= TDI;
    end
  end

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      idcode_q <= IDCODE_VAL;
    end else if (idcodeSel && fsmState == CAPDR) begin
      idcode_q <= IDCODE_VAL;
    end else if (idcodeSel && fsmState == SHDR) begin
      idcode_q <= {TDI, idcode_q[31:1]};
    end
  end

  // Falling-edge side: TLR forces IDCODE so a TMS-only reset matches TRST.
  always_ff @(negedge TCK or posedge TRST) begin
    if (TRST) begin
      irActive_q <= IR_WIDTH'(OP_IDCODE);
      tdo_q      <= 1'b0;
      tdoEn_q    <= 1'b0;
    end else begin
      if (fsmState == UPDIR) begin
        irActive_q <= irShift_q;
      end else if (fsmState == TLR) begin
        irActive_q <= IR_WIDTH'(OP_IDCODE);
      end
      tdo_q   <= tdo_d;
      tdoEn_q <= tdoEn_d;
    end
  end

  always_comb begin
    bsrSel    = (irActive_q == IR_WIDTH'(OP_EXTEST)) || (irActive_q == IR_WIDTH'(OP_SAMPLE));
    idcodeSel = (irActive_q == IR_WIDTH'(OP_IDCODE));
    drBit     = bsrSel ? bsr_so : (idcodeSel ? idcode_q[0] : bypass_q);
    tdo_d     = 1'b0;
    tdoEn_d   = 1'b0;
    if (fsmState == SHIR) begin
      tdo_d   = irShift_q[0];
      tdoEn_d = 1'b1;
    end else if (fsmState == SHDR) begin
      tdo_d   = drBit;
      tdoEn_d = 1'b1;
    end
  end

  assign mode      = (irActive_q == IR_WIDTH'(OP_EXTEST));
  assign ShiftDR   = (fsmState == SHDR)  && bsrSel;
  assign CaptureDR = (fsmState == CAPDR) && bsrSel;
  assign UpdateDR  = (fsmState == UPDDR) && bsrSel;
  assign TDO       = tdo_q;
  assign tdo_en    = tdoEn_q;

endmodule

// File: tb/tb_tap_ctrl.sv
// Scoreboard bench for tap_ctrl: directed TMS/TDI walks queue expectations, a monitor checks them.
module tb_tap_ctrl;

  logic       TCK = 1'b0;
  logic       TRST, TMS, TDI, bsrSo;
  logic       TDO, tdoEn, shiftDr, captureDr, updateDr, mode;
  logic [3:0] state;

  int testCount = 0;
  int failCount = 0;
  int posCount  = 0;

  typedef struct {
    int         cyc;
    int         field;
    logic [3:0] exp;
    string      name;
  } chkItem_t;

  chkItem_t chkQ[$];
  logic     tdoQ[$];

  tap_ctrl #(
    .IR_WIDTH   (4),
    .IDCODE_VAL (32'h1000_0001)
  ) dut (
    .TCK       (TCK),
    .TRST      (TRST),
    .TMS       (TMS),
    .TDI       (TDI),
    .bsr_so    (bsrSo),
    .TDO       (TDO),
    .tdo_en    (tdoEn),
    .ShiftDR   (shiftDr),
    .CaptureDR (captureDr),
    .UpdateDR  (updateDr),
    .mode      (mode),
    .state     (state)
  );

  always #5 TCK = ~TCK;

  always @(posedge TCK) posCount++;

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, posCount);
    end
  endtask

  task automatic pushChk(input int field, input logic [3:0] exp, input string name);
    chkItem_t it;
    it.cyc   = posCount;
    it.field = field;
    it.exp   = exp;
    it.name  = name;
    chkQ.push_back(it);
  endtask

  task automatic expectStatus(input string tag, input logic [3:0] st, input logic md,
                              input logic sh, input logic cap, input logic upd);
    pushChk(0, st, {tag, "_state"});
    pushChk(1, {3'b000, md}, {tag, "_mode"});
    pushChk(2, {3'b000, sh}, {tag, "_ShiftDR"});
    pushChk(3, {3'b000, cap}, {tag, "_CaptureDR"});
    pushChk(4, {3'b000, upd}, {tag, "_UpdateDR"});
  endtask

  task automatic applyStimulus(input logic tms, input logic tdi, input logic bso);
    @(negedge TCK);
    #2;
    TMS   = tms;
    TDI   = tdi;
    bsrSo = bso;
    @(posedge TCK);
    #1;
  endtask

  task automatic stepExpect(input logic tms, input logic tdi, input logic bso,
                            input logic [3:0] st, input logic md, input logic sh,
                            input logic cap, input logic upd, input string tag);
    applyStimulus(tms, tdi, bso);
    expectStatus(tag, st, md, sh, cap, upd);
  endtask

  // Full IR scan from RTI back to RTI; tdoExp lists the captured bits seen on TDO, LSB first.
  task automatic loadIr(input logic [3:0] code, input logic [3:0] tdoExp,
                        input logic modeBefore, input logic modeAfter);
    stepExpect(1, 0, 0, 4'h7, modeBefore, 0, 0, 0, "ir_seldr");
    stepExpect(1, 0, 0, 4'h4, modeBefore, 0, 0, 0, "ir_selir");
    stepExpect(0, 0, 0, 4'hE, modeBefore, 0, 0, 0, "ir_capir");
    for (int i = 0; i < 4; i++) tdoQ.push_back(tdoExp[i]);
    stepExpect(0, 0, 0, 4'hA, modeBefore, 0, 0, 0, "ir_shir");
    for (int i = 0; i < 3; i++) stepExpect(0, code[i], 0, 4'hA, modeBefore, 0, 0, 0, "ir_shift");
    stepExpect(1, code[3], 0, 4'h9, modeBefore, 0, 0, 0, "ir_ex1");
    stepExpect(1, 0, 0, 4'hD, modeAfter, 0, 0, 0, "ir_upd");
    stepExpect(0, 0, 0, 4'hC, modeAfter, 0, 0, 0, "ir_rti");
  endtask

  task automatic releaseReset();
    @(negedge TCK);
    #2;
    TRST = 1'b0;
    TMS  = 1'b0;
    @(posedge TCK);
    #1;
    expectStatus("rst_rti", 4'hC, 0, 0, 0, 0);
  endtask

  // Monitor: status checks fire in their tagged cycle, TDO is popped whenever tdo_en is high.
  initial begin
    chkItem_t   it;
    logic [3:0] act;
    logic       expBit;
    forever begin
      @(negedge TCK);
      #1;
      while (chkQ.size() > 0 && chkQ[0].cyc <= posCount) begin
        it = chkQ.pop_front();
        case (it.field)
          0:       act = state;
          1:       act = {3'b000, mode};
          2:       act = {3'b000, shiftDr};
          3:       act = {3'b000, captureDr};
          4:       act = {3'b000, updateDr};
          5:       act = {3'b000, tdoEn};
          default: act = {3'b000, TDO};
        endcase
        checkOutput(it.name, act, it.exp);
      end
      if (tdoEn === 1'b1) begin
        if (tdoQ.size() == 0) begin
          testCount++;
          failCount++;
          $display("[TB] FAIL tdo_unexpected: tdo_en=1 with TDO=%b, expected no output (cycle %0d)",
                   TDO, posCount);
        end else begin
          expBit = tdoQ.pop_front();
          checkOutput("tdo", {3'b000, TDO}, {3'b000, expBit});
        end
      end
    end
  end

  initial begin
    #100000;
    failCount++;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  initial begin
    logic [31:0] idVal;
    idVal = 32'h1000_0001;
    TRST  = 1'b1;
    TMS   = 1'b1;
    TDI   = 1'b0;
    bsrSo = 1'b0;

    // Reset state, then one TMS=0 clock into RTI
    repeat (2) @(posedge TCK);
    #1;
    expectStatus("reset", 4'hF, 0, 0, 0, 0);
    pushChk(5, 4'h0, "reset_tdo_en");
    pushChk(6, 4'h0, "reset_tdo");
    releaseReset();

    // IDCODE is the default instruction: 32 bits out LSB first, no BSR strobes
    stepExpect(1, 0, 0, 4'h7, 0, 0, 0, 0, "id_seldr");
    stepExpect(0, 0, 0, 4'h6, 0, 0, 0, 0, "id_capdr");
    for (int i = 0; i < 32; i++) tdoQ.push_back(idVal[i]);
    stepExpect(0, 0, 1, 4'h2, 0, 0, 0, 0, "id_shdr");
    for (int i = 0; i < 31; i++) stepExpect(0, 0, 1, 4'h2, 0, 0, 0, 0, "id_shift");
    stepExpect(1, 0, 0, 4'h1, 0, 0, 0, 0, "id_ex1");
    stepExpect(1, 0, 0, 4'h5, 0, 0, 0, 0, "id_upd");
    stepExpect(0, 0, 0, 4'hC, 0, 0, 0, 0, "id_rti");

    // Load EXTEST; mode rises at the UPDIR falling edge
    loadIr(4'b0000, 4'b0001, 0, 1);

    // EXTEST DR walk: capture 1, shift 4, update 1; TDO echoes bsr_so
    stepExpect(1, 0, 0, 4'h7, 1, 0, 0, 0, "ex_seldr");
    stepExpect(0, 0, 1, 4'h6, 1, 0, 1, 0, "ex_capdr");
    tdoQ.push_back(1'b1);
    tdoQ.push_back(1'b0);
    tdoQ.push_back(1'b1);
    tdoQ.push_back(1'b1);
    stepExpect(0, 0, 1, 4'h2, 1, 1, 0, 0, "ex_sh0");
    stepExpect(0, 0, 0, 4'h2, 1, 1, 0, 0, "ex_sh1");
    stepExpect(0, 0, 1, 4'h2, 1, 1, 0, 0, "ex_sh2");
    stepExpect(0, 0, 1, 4'h2, 1, 1, 0, 0, "ex_sh3");
    stepExpect(1, 0, 0, 4'h1, 1, 0, 0, 0, "ex_ex1");
    stepExpect(1, 0, 0, 4'h5, 1, 0, 0, 1, "ex_upd");
    stepExpect(0, 0, 0, 4'hC, 1, 0, 0, 0, "ex_rti");

    // TRST in the middle of an IR shift: partial IR dropped, IDCODE active at once
    stepExpect(1, 0, 0, 4'h7, 1, 0, 0, 0, "mid_seldr");
    stepExpect(1, 0, 0, 4'h4, 1, 0, 0, 0, "mid_selir");
    stepExpect(0, 0, 0, 4'hE, 1, 0, 0, 0, "mid_capir");
    tdoQ.push_back(1'b1);
    tdoQ.push_back(1'b0);
    stepExpect(0, 0, 0, 4'hA, 1, 0, 0, 0, "mid_shir");
    stepExpect(0, 1, 0, 4'hA, 1, 0, 0, 0, "mid_shift");
    @(negedge TCK);
    #2;
    TRST = 1'b1;
    #1;
    checkOutput("async_state", state, 4'hF);
    checkOutput("async_mode", {3'b000, mode}, 4'h0);
    checkOutput("async_tdo_en", {3'b000, tdoEn}, 4'h0);
    @(posedge TCK);
    #1;
    expectStatus("mid_rst", 4'hF, 0, 0, 0, 0);
    releaseReset();
    stepExpect(1, 0, 1, 4'h7, 0, 0, 0, 0, "mid_id_seldr");
    stepExpect(0, 0, 1, 4'h6, 0, 0, 0, 0, "mid_id_capdr");
    tdoQ.push_back(1'b1);
    tdoQ.push_back(1'b0);
    stepExpect(0, 0, 1, 4'h2, 0, 0, 0, 0, "mid_id_sh0");
    stepExpect(0, 0, 1, 4'h2, 0, 0, 0, 0, "mid_id_sh1");
    stepExpect(1, 0, 1, 4'h1, 0, 0, 0, 0, "mid_id_ex1");
    stepExpect(1, 0, 0, 4'h5, 0, 0, 0, 0, "mid_id_upd");
    stepExpect(0, 0, 0, 4'hC, 0, 0, 0, 0, "mid_id_rti");

    // Undefined opcode 1010 acts as BYPASS; a pause mid-shift loses no bit
    loadIr(4'b1010, 4'b0001, 0, 0);
    stepExpect(1, 0, 1, 4'h7, 0, 0, 0, 0, "by_seldr");
    stepExpect(0, 0, 1, 4'h6, 0, 0, 0, 0, "by_capdr");
    tdoQ.push_back(1'b0);
    tdoQ.push_back(1'b1);
    tdoQ.push_back(1'b0);
    tdoQ.push_back(1'b1);
    stepExpect(0, 0, 1, 4'h2, 0, 0, 0, 0, "by_sh0");
    stepExpect(0, 1, 1, 4'h2, 0, 0, 0, 0, "by_sh1");
    stepExpect(1, 0, 1, 4'h1, 0, 0, 0, 0, "by_ex1");
    stepExpect(0, 1, 1, 4'h3, 0, 0, 0, 0, "by_pause");
    stepExpect(1, 1, 1, 4'h0, 0, 0, 0, 0, "by_ex2");
    stepExpect(0, 1, 1, 4'h2, 0, 0, 0, 0, "by_sh2");
    stepExpect(0, 1, 1, 4'h2, 0, 0, 0, 0, "by_sh3");
    stepExpect(1, 0, 1, 4'h1, 0, 0, 0, 0, "by_ex1b");
    stepExpect(1, 0, 0, 4'h5, 0, 0, 0, 0, "by_upd");
    stepExpect(0, 0, 0, 4'hC, 0, 0, 0, 0, "by_rti");

    // EXTEST again, park in PAUSEDR, then five TMS=1 clocks reach TLR and drop mode
    loadIr(4'b0000, 4'b0001, 0, 1);
    stepExpect(1, 0, 0, 4'h7, 1, 0, 0, 0, "tl_seldr");
    stepExpect(0, 0, 0, 4'h6, 1, 0, 1, 0, "tl_capdr");
    stepExpect(1, 0, 0, 4'h1, 1, 0, 0, 0, "tl_ex1");
    stepExpect(0, 0, 0, 4'h3, 1, 0, 0, 0, "tl_pause");
    stepExpect(1, 0, 0, 4'h0, 1, 0, 0, 0, "tl_ex2");
    stepExpect(1, 0, 0, 4'h5, 1, 0, 0, 1, "tl_upd");
    stepExpect(1, 0, 0, 4'h7, 1, 0, 0, 0, "tl_seldr2");
    stepExpect(1, 0, 0, 4'h4, 1, 0, 0, 0, "tl_selir");
    stepExpect(1, 0, 0, 4'hF, 0, 0, 0, 0, "tl_tlr");
    stepExpect(0, 0, 1, 4'hC, 0, 0, 0, 0, "tl_rti");
    stepExpect(1, 0, 1, 4'h7, 0, 0, 0, 0, "tl_id_seldr");
    stepExpect(0, 0, 1, 4'h6, 0, 0, 0, 0, "tl_id_capdr");
    tdoQ.push_back(1'b1);
    tdoQ.push_back(1'b0);
    tdoQ.push_back(1'b0);
    tdoQ.push_back(1'b0);
    stepExpect(0, 0, 1, 4'h2, 0, 0, 0, 0, "tl_id_sh0");
    for (int i = 0; i < 3; i++) stepExpect(0, 0, 1, 4'h2, 0, 0, 0, 0, "tl_id_sh");
    stepExpect(1, 0, 1, 4'h1, 0, 0, 0, 0, "tl_id_ex1");
    stepExpect(1, 0, 0, 4'h5, 0, 0, 0, 0, "tl_id_upd");
    stepExpect(0, 0, 0, 4'hC, 0, 0, 0, 0, "tl_id_rti");

    repeat (3) @(posedge TCK);
    #1;
    testCount++;
    if (chkQ.size() != 0 || tdoQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL drain: %0d status and %0d TDO expectations left, expected 0 and 0",
               chkQ.size(), tdoQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
